// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage execute unit: opcodes, FSM states and
// opcode classification helpers.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b0_0000;
    localparam logic [4:0] OP_SUB    = 5'b0_0001;
    localparam logic [4:0] OP_AND    = 5'b0_0010;
    localparam logic [4:0] OP_OR     = 5'b0_0011;
    localparam logic [4:0] OP_XOR    = 5'b0_0100;
    localparam logic [4:0] OP_SLL    = 5'b0_0101;
    localparam logic [4:0] OP_SRL    = 5'b0_0110;
    localparam logic [4:0] OP_SRA    = 5'b0_0111;
    localparam logic [4:0] OP_SLT    = 5'b0_1000;
    localparam logic [4:0] OP_SLTU   = 5'b0_1001;
    localparam logic [4:0] OP_MUL    = 5'b1_0000;
    localparam logic [4:0] OP_MULH   = 5'b1_0001;
    localparam logic [4:0] OP_MULHSU = 5'b1_0010;
    localparam logic [4:0] OP_MULHU  = 5'b1_0011;
    localparam logic [4:0] OP_DIV    = 5'b1_0100;
    localparam logic [4:0] OP_DIVU   = 5'b1_0101;
    localparam logic [4:0] OP_REM    = 5'b1_0110;
    localparam logic [4:0] OP_REMU   = 5'b1_0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return op[4] && !op[3];
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return is_mdu_op(op) && op[2];
    endfunction

    // DIV and REM are the signed divide forms (op[0] clear).
    function automatic logic is_signed_div(input logic [4:0] op);
        return is_div_op(op) && !op[0];
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: shift-add multiplier and restoring divider, one bit
// per cycle, sharing one XLEN+1 bit adder; operates on magnitudes with sign fix-up.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic            run;
    logic [CW-1:0]   step;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;

    logic            a_sgn, b_sgn, a_neg, b_neg, start_neg, is_mul;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   add_x, add_y, sum;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s;

    assign a_sgn = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_sgn = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign a_neg = a_sgn && a[XLEN-1];
    assign b_neg = b_sgn && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    // Remainder follows the dividend; everything else follows the sign product.
    assign start_neg = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);

    assign is_mul = !op_q[2];
    assign add_x  = is_mul ? hi : {hi[XLEN-1:0], lo[XLEN-1]};
    assign add_y  = is_mul ? (lo[0] ? {1'b0, opnd} : '0) : ~{1'b0, opnd};
    assign sum    = add_x + add_y + {{XLEN{1'b0}}, !is_mul};

    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            step  <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
        end else if (flush) begin
            run <= 1'b0;
        end else if (start) begin
            run   <= 1'b1;
            step  <= CW'(XLEN - 1);
            op_q  <= op;
            neg_q <= start_neg;
            hi    <= '0;
            lo    <= a_mag;
            opnd  <= b_mag;
        end else if (run) begin
            if (is_mul) begin
                hi <= {1'b0, sum[XLEN:1]};
                lo <= {sum[0], lo[XLEN-1:1]};
            end else if (sum[XLEN]) begin
                hi <= add_x;
                lo <= {lo[XLEN-2:0], 1'b0};
            end else begin
                hi <= sum;
                lo <= {lo[XLEN-2:0], 1'b1};
            end
            step <= step - 1'b1;
            if (step == '0) run <= 1'b0;
        end
    end

    assign done   = run && (step == '0);
    assign prod   = {hi[XLEN-1:0], lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -lo : lo;
    assign rem_s  = neg_q ? -hi[XLEN-1:0] : hi[XLEN-1:0];

    always_comb begin
        result = rem_s;
        case (op_q)
            3'b000:                 result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quo_s;
            default:                result = rem_s;
        endcase
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// Registered EX-stage execute unit: 1-cycle base ALU plus iterative RV32M ops.
// state | meaning:  IDLE | empty, ready  ;  BUSY | mdu iterating  ;  DONE | result held until out_ready
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int M_EXT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state, state_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [XLEN-1:0]  res_q, quick, mdu_res;
    logic             from_mdu_q, mdu_done;
    logic [TAG_W-1:0] tag_q, tag_out_q;
    logic             accept, iter_op, div_zero, div_ovf;
    logic [SHW-1:0]   sh;

    assign div_zero = (in_b == '0);
    assign div_ovf  = (in_a == MIN_VAL) && (in_b == '1);
    assign iter_op  = (M_EXT != 0) && is_mdu_op(in_op) &&
                      !(is_div_op(in_op) && (div_zero || (is_signed_div(in_op) && div_ovf)));
    assign sh       = in_b[SHW-1:0];

    always_comb begin
        quick = '0;
        case (in_op)
            OP_ADD:  quick = in_a + in_b;
            OP_SUB:  quick = in_a - in_b;
            OP_AND:  quick = in_a & in_b;
            OP_OR:   quick = in_a | in_b;
            OP_XOR:  quick = in_a ^ in_b;
            OP_SLL:  quick = in_a << sh;
            OP_SRL:  quick = in_a >> sh;
            OP_SRA:  quick = $signed(in_a) >>> sh;
            OP_SLT:  quick = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU: quick = {{(XLEN-1){1'b0}}, in_a < in_b};
            OP_DIV, OP_DIVU: begin
                if (div_zero)                        quick = '1;
                else if (in_op == OP_DIV && div_ovf) quick = in_a;
            end
            OP_REM, OP_REMU: begin
                if (div_zero) quick = in_a;
            end
            default: quick = '0;
        endcase
        if (M_EXT == 0 && is_mdu_op(in_op)) quick = '0;
    end

    assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = iter_op ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (cnt != '0)    cnt_n   = cnt - 1'b1;
                else if (mdu_done) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (accept)         state_n = iter_op ? ST_BUSY : ST_DONE;
                else if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (accept && iter_op) cnt_n = SHW'(XLEN - 1);
        if (flush) state_n = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            res_q      <= '0;
            from_mdu_q <= 1'b0;
            tag_q      <= '0;
            tag_out_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                if (iter_op) begin
                    // Freeze the visible result so the running mdu never shows through.
                    tag_q      <= in_tag;
                    res_q      <= out_result;
                    from_mdu_q <= 1'b0;
                end else begin
                    res_q      <= quick;
                    from_mdu_q <= 1'b0;
                    tag_out_q  <= in_tag;
                end
            end else if (state == ST_BUSY && state_n == ST_DONE) begin
                from_mdu_q <= 1'b1;
                tag_out_q  <= tag_q;
            end
        end
    end

    generate
        if (M_EXT != 0) begin : g_mdu
            mdu_iter #(.XLEN(XLEN)) u_mdu (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .start  (accept && iter_op),
                .op     (in_op[2:0]),
                .a      (in_a),
                .b      (in_b),
                .done   (mdu_done),
                .result (mdu_res)
            );
        end else begin : g_no_mdu
            assign mdu_done = 1'b0;
            assign mdu_res  = '0;
        end
    endgenerate

    assign out_result = from_mdu_q ? mdu_res : res_q;
    assign out_zero   = (out_result == '0);
    assign out_tag    = tag_out_q;
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state == ST_BUSY);

endmodule
